wb_sequencer: RTL and testbench
===============================

// Module: wb_sequencer
// PURPOSE
//  Multicycle write-back controller for the register-file write port. It takes one write-back
//  request per instruction from main control and waits for load data where needed. It then drives
//  the MemtoReg selector, the destination register and a single-cycle reg_write strobe.
//  It sits between the main control FSM and the MemtoReg mux / register bank.
// PARAMETERS
//  SEL_W    4    width of MemtoReg selector
//  REG_W    5    register-address width
//  TIMEOUT  16   max cycles waiting for mem_ready before error (>=2)
//  CNT_W    16   width of stall performance counter
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-low reset
//  start          in   1      1-cycle request pulse from main control
//  src_sel        in   SEL_W  requested MemtoReg code (valid 0..8)
//  dest_reg       in   REG_W  destination register
//  is_load        in   1      source data comes from memory; wait for mem_ready
//  mem_ready      in   1      memory data register valid this cycle
//  memtoreg_sel   out  SEL_W  selector to MemtoReg mux
//  write_reg      out  REG_W  register-bank write address
//  reg_write      out  1      register-bank write enable (1-cycle strobe)
//  busy           out  1      request in progress (not IDLE)
//  done           out  1      1-cycle completion pulse
//  err            out  1      qualifies done: request aborted, no write
//  stall_cnt      out  CNT_W  total cycles spent in MEM_WAIT (saturating)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, all outputs 0, stall_cnt=0, latches cleared.
//  States: IDLE, MEM_WAIT, WRITE, DONE, ERR.
//  IDLE: start=1 latches src_sel, dest_reg, is_load.
//   src_sel>8 -> ERR. is_load=1 -> MEM_WAIT. Otherwise -> WRITE.
//  MEM_WAIT: mem_ready=1 -> WRITE.
//   Else wait counter increments; counter reaching TIMEOUT-1 without ready -> ERR.
//   stall_cnt += 1 each cycle here, saturating at all-ones.
//  WRITE: memtoreg_sel=latched src, write_reg=latched dest.
//   reg_write=1 for exactly this cycle, except dest==0, which suppresses reg_write (r0 read-only).
//   -> DONE.
//  DONE: done=1, err=0 for one cycle -> IDLE.
//  ERR: done=1, err=1 for one cycle, reg_write=0 -> IDLE.
//  memtoreg_sel and write_reg hold the latched values from latch until the return to IDLE.
//   They are 0 in IDLE.
//  busy=1 in every state except IDLE. start while busy is ignored; no queueing.
//  Latency, non-load: start at cycle N -> reg_write N+1, done N+2.
//  Latency, load: reg_write comes 1 cycle after the mem_ready sample. mem_ready in the start cycle
//   is not sampled.
//  Code 7 selects the mux constant 0xE3 and is a legal write source.
//  Reset mid-operation: immediate return to IDLE. No partial write; reg_write drops asynchronously.
// STRUCTURE
//  Shared package wb_pkg:
//   state enum.
//   selector constants SEL_D0..SEL_D6=0..6, SEL_CONST_E3=7, SEL_D7=8, SEL_MAX=8.
//  One sub-module wb_timeout_ctr: clear/enable/expired counter, sized from TIMEOUT.
//  Everything else is flat in wb_sequencer.
// TESTING
//  1 Reset: reset=0 mid-MEM_WAIT -> all outputs 0 same cycle; after release, busy=0, stall_cnt=0.
//  2 ALU write: start, src=0, dest=8, is_load=0 at cycle 5 ->
//     reg_write=1, sel=0, wr=8 at cycle 6; done=1, err=0 at cycle 7.
//  3 Load: start, src=1, dest=9, is_load=1; mem_ready high after 3 wait cycles ->
//     reg_write 1 cycle later; stall_cnt=3.
//  4 Timeout: is_load=1, mem_ready held 0 -> ERR after TIMEOUT cycles;
//     done=1, err=1, no reg_write ever.
//  5 Edge codes: src=9 -> immediate ERR. src=7, dest=31 -> write with sel=7.
//     dest=0 -> done with reg_write never 1.
//  6 Back-pressure: pulse start every cycle during a load -> only the first is accepted.
//     Latched dest is unchanged by the extra pulses.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and selector codes for the register-file write-back sequencer.
package wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_WRITE    = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } wb_state_e;

    // MemtoReg mux codes; code 7 picks the 0xE3 constant, not a data source
    localparam int unsigned SEL_D0       = 0;
    localparam int unsigned SEL_D1       = 1;
    localparam int unsigned SEL_D2       = 2;
    localparam int unsigned SEL_D3       = 3;
    localparam int unsigned SEL_D4       = 4;
    localparam int unsigned SEL_D5       = 5;
    localparam int unsigned SEL_D6       = 6;
    localparam int unsigned SEL_CONST_E3 = 7;
    localparam int unsigned SEL_D7       = 8;
    localparam int unsigned SEL_MAX      = 8;

endpackage

// File: rtl/wb_sequencer_if.sv
// Request/response bundle between main control, memory-ready and the write-back sequencer.
interface wb_sequencer_if #(
    parameter int SEL_W = 4,
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             start;
    logic [SEL_W-1:0] src_sel;
    logic [REG_W-1:0] dest_reg;
    logic             is_load;
    logic             mem_ready;
    logic [SEL_W-1:0] memtoreg_sel;
    logic [REG_W-1:0] write_reg;
    logic             reg_write;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output start, src_sel, dest_reg, is_load, mem_ready,
        input  memtoreg_sel, write_reg, reg_write, busy, done, err, stall_cnt
    );

    modport slave (
        input  start, src_sel, dest_reg, is_load, mem_ready,
        output memtoreg_sel, write_reg, reg_write, busy, done, err, stall_cnt
    );
endinterface

// File: rtl/wb_timeout_ctr.sv
// Wait-cycle counter for MEM_WAIT: expired flags the last permitted cycle without mem_ready.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Hold at the terminal value; the FSM leaves MEM_WAIT on that cycle anyway
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == LAST);
endmodule

// File: rtl/wb_sequencer.sv
// Multicycle write-back controller driving MemtoReg select, write address and reg_write strobe.
//
// state    | meaning
// IDLE     | waiting for start; outputs 0
// MEM_WAIT | load request, waiting for mem_ready (bounded by TIMEOUT)
// WRITE    | one-cycle reg_write strobe (suppressed for r0)
// DONE     | done pulse, err=0
// ERR      | done pulse, err=1, no write performed
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input logic           clk,
    input logic           reset,
    wb_sequencer_if.slave bus
);
    localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(SEL_MAX);

    wb_state_e        state_q, state_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [REG_W-1:0] dest_q, dest_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             wait_expired;

    wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q != ST_MEM_WAIT),
        .en_i      (state_q == ST_MEM_WAIT),
        .expired_o (wait_expired)
    );

    // Next-state, request capture and stall accounting
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dest_d  = dest_q;
        stall_d = stall_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    src_d  = bus.src_sel;
                    dest_d = bus.dest_reg;
                    if (bus.src_sel > SEL_LIMIT) state_d = ST_ERR;
                    else if (bus.is_load)        state_d = ST_MEM_WAIT;
                    else                         state_d = ST_WRITE;
                end
            end
            ST_MEM_WAIT: begin
                if (stall_q != '1) stall_d = stall_q + 1'b1;
                if (bus.mem_ready)      state_d = ST_WRITE;
                else if (wait_expired)  state_d = ST_ERR;
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dest_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dest_q  <= dest_d;
            stall_q <= stall_d;
        end
    end

    // Outputs decode from the state register so reset clears them without waiting for a clock
    always_comb begin
        bus.busy         = (state_q != ST_IDLE);
        bus.memtoreg_sel = (state_q != ST_IDLE) ? src_q  : '0;
        bus.write_reg    = (state_q != ST_IDLE) ? dest_q : '0;
        bus.reg_write    = (state_q == ST_WRITE) && (dest_q != '0);
        bus.done         = (state_q == ST_DONE) || (state_q == ST_ERR);
        bus.err          = (state_q == ST_ERR);
        bus.stall_cnt    = stall_q;
    end
endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer with hand-computed expectations.
module tb_wb_sequencer;
    localparam int SEL_W   = 4;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    logic seen_bad;

    wb_sequencer_if #(.SEL_W(SEL_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    wb_sequencer #(
        .SEL_W(SEL_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int src, input int dst, input logic ld);
        bus.start    = 1'b1;
        bus.src_sel  = SEL_W'(src);
        bus.dest_reg = REG_W'(dst);
        bus.is_load  = ld;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.src_sel = '0; bus.dest_reg = '0;
        bus.is_load = 1'b0; bus.mem_ready = 1'b0;
        #23 reset = 1'b1;
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        chk("rst_sel", bus.memtoreg_sel, 0);

        // reset in the middle of MEM_WAIT
        req(1, 9, 1'b1);
        tick();
        bus.start = 1'b0;
        chk("mw_busy", bus.busy, 1);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_stall", bus.stall_cnt, 0);
        chk("arst_outs", {bus.memtoreg_sel, bus.write_reg, bus.reg_write, bus.done, bus.err}, 0);
        #3 reset = 1'b1;
        tick();
        chk("rel_busy", bus.busy, 0);
        chk("rel_stall", bus.stall_cnt, 0);

        // reset during WRITE kills the strobe immediately
        req(0, 3, 1'b0);
        tick();
        bus.start = 1'b0;
        chk("w_strobe", bus.reg_write, 1);
        #2 reset = 1'b0;
        #1;
        chk("w_arst", bus.reg_write, 0);
        #3 reset = 1'b1;
        tick();

        // ALU write: reg_write next cycle, done the one after
        req(0, 8, 1'b0);
        tick();
        bus.start = 1'b0;
        chk("alu_rw", bus.reg_write, 1);
        chk("alu_sel", bus.memtoreg_sel, 0);
        chk("alu_wr", bus.write_reg, 8);
        chk("alu_busy", bus.busy, 1);
        tick();
        chk("alu_done", {bus.done, bus.err, bus.reg_write}, 3'b100);
        tick();
        chk("alu_idle", {bus.busy, bus.done, bus.write_reg}, 0);

        // load: ready sampled on the third MEM_WAIT cycle
        req(1, 9, 1'b1);
        bus.mem_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mem_ready = 1'b0;
        chk("ld_wait0", {bus.busy, bus.reg_write}, 2'b10);
        tick();
        tick();
        chk("ld_wait2", bus.reg_write, 0);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("ld_rw", bus.reg_write, 1);
        chk("ld_sel", bus.memtoreg_sel, 1);
        chk("ld_wr", bus.write_reg, 9);
        chk("ld_stall", bus.stall_cnt, 3);
        tick();
        chk("ld_done", {bus.done, bus.err}, 2'b10);
        tick();

        // timeout: TIMEOUT cycles of MEM_WAIT then ERR
        req(2, 10, 1'b1);
        tick();
        bus.start = 1'b0;
        seen_bad = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (bus.reg_write || bus.done || !bus.busy) seen_bad = 1'b1;
            tick();
        end
        chk("to_quiet", seen_bad, 0);
        chk("to_err", {bus.done, bus.err, bus.reg_write}, 3'b110);
        chk("to_wr", bus.write_reg, 10);
        chk("to_stall", bus.stall_cnt, 3 + TIMEOUT);
        tick();
        chk("to_idle", {bus.busy, bus.done, bus.err}, 0);

        // illegal code 9 aborts at once
        req(9, 5, 1'b0);
        tick();
        bus.start = 1'b0;
        chk("c9_err", {bus.done, bus.err, bus.reg_write}, 3'b110);
        tick();

        // constant code 7 to r31
        req(7, 31, 1'b0);
        tick();
        bus.start = 1'b0;
        chk("c7_rw", {bus.reg_write, bus.memtoreg_sel, bus.write_reg}, {1'b1, 4'd7, 5'd31});
        tick();
        chk("c7_done", {bus.done, bus.err}, 2'b10);
        tick();

        // r0 destination: completes without a write
        req(3, 0, 1'b0);
        tick();
        bus.start = 1'b0;
        chk("r0_rw", {bus.reg_write, bus.busy, bus.memtoreg_sel}, {1'b0, 1'b1, 4'd3});
        tick();
        chk("r0_done", {bus.done, bus.err, bus.reg_write}, 3'b100);
        tick();

        // start held during a load is ignored
        req(4, 12, 1'b1);
        tick();
        req(5, 20, 1'b0);
        tick();
        req(6, 21, 1'b1);
        tick();
        chk("bp_hold", {bus.write_reg, bus.memtoreg_sel}, {5'd12, 4'd4});
        bus.mem_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mem_ready = 1'b0;
        chk("bp_rw", {bus.reg_write, bus.memtoreg_sel, bus.write_reg}, {1'b1, 4'd4, 5'd12});
        chk("bp_stall", bus.stall_cnt, 3 + TIMEOUT + 3);
        tick();
        chk("bp_done", {bus.done, bus.err}, 2'b10);
        tick();
        chk("bp_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
